// File: rtl/decode_stage_pkg.sv
// Uop package: micro-op types, RV32I opcode/funct constants and exception causes
// shared by the decode stage and its downstream consumers.
package Uop;

   typedef logic [31:0] val_t;
   typedef logic [4:0]  regIdx_t;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      FU_NONE   = 2'd0,
      FU_INTALU = 2'd1
   } fu_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } intaluOp_e;

   typedef enum logic [3:0] {
      EXC_NONE          = 4'd0,
      EXC_ILLEGAL_INSTR = 4'd2
   } excCause_e;

   typedef struct packed {
      val_t      pc;
      excCause_e cause;
      val_t      tval;
   } ex_t;

   typedef struct packed {
      fu_e       fu;
      intaluOp_e op;
      regIdx_t   rd;
      regIdx_t   rs1;
      regIdx_t   rs2;
      val_t      rs1val;
      val_t      rs2val;
      val_t      imm;
      logic      immValid;
      ex_t       ex;
   } decode_t;

   function automatic val_t sextImmI(input logic [31:0] instr);
      logic signed [11:0] immS;
      logic signed [31:0] wideS;
      immS  = signed'(instr[31:20]);
      wideS = 32'(immS);
      return val_t'(wideS);
   endfunction

endpackage

// File: rtl/pipeline_if.sv
// Valid/stall link between adjacent pipeline stages; the consumer drives stall.
interface pipeline_if;

   logic valid;
   logic stall;

   modport Upstream   (input valid, output stall);
   modport Downstream (output valid, input stall);

endinterface

// File: rtl/decode_stage_instr_decoder.sv
// Combinational RV32I decoder for the integer-ALU subset (OP, OP-IMM, LUI).
// Register values and exception info are left zero; the stage fills them in.
module instr_decoder
   import Uop::*;
(
   input  logic [31:0] instr,
   output decode_t     dec,
   output logic        legal
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opc = instr[6:0];
   assign f3  = instr[14:12];
   assign f7  = instr[31:25];

   function automatic intaluOp_e baseOp(input logic [2:0] fn3);
      intaluOp_e r;
      case (fn3)
         F3_ADD:  r = ALU_ADD;
         F3_SLL:  r = ALU_SLL;
         F3_SLT:  r = ALU_SLT;
         F3_SLTU: r = ALU_SLTU;
         F3_XOR:  r = ALU_XOR;
         F3_SR:   r = ALU_SRL;
         F3_OR:   r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

   always_comb begin
      dec   = '0;
      legal = 1'b0;
      case (opc)
         OPC_OP: begin
            // Only ADD/SRL have an alternate (funct7[5]) form: SUB/SRA.
            legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
            if (legal) begin
               dec.fu  = FU_INTALU;
               dec.rd  = instr[11:7];
               dec.rs1 = instr[19:15];
               dec.rs2 = instr[24:20];
               if (f7 == F7_ALT)
                  dec.op = (f3 == F3_ADD) ? ALU_SUB : ALU_SRA;
               else
                  dec.op = baseOp(f3);
            end
         end
         OPC_OPIMM: begin
            case (f3)
               F3_SLL:  legal = (f7 == F7_BASE);
               F3_SR:   legal = (f7 == F7_BASE) || (f7 == F7_ALT);
               default: legal = 1'b1;
            endcase
            if (legal) begin
               dec.fu       = FU_INTALU;
               dec.rd       = instr[11:7];
               dec.rs1      = instr[19:15];
               dec.imm      = sextImmI(instr);
               dec.immValid = 1'b1;
               dec.op       = ((f3 == F3_SR) && (f7 == F7_ALT)) ? ALU_SRA : baseOp(f3);
            end
         end
         OPC_LUI: begin
            legal        = 1'b1;
            dec.fu       = FU_INTALU;
            dec.op       = ALU_ADD;
            dec.rd       = instr[11:7];
            dec.imm      = {instr[31:12], 12'b0};
            dec.immValid = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-entry stall buffer, register-file read and registered uop output.
// Optional macro DECODE_ILLEGAL_TRAP_EN turns illegal encodings into trapping uops.
module decode_stage
   import Uop::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   pipeline_if.Upstream             u,
   pipeline_if.Downstream           d,
   input  logic [31:0]              instrIn,
   input  logic [XLEN-1:0]          pcIn,
   output logic [$clog2(NREGS)-1:0] rfRs1Addr,
   output logic [$clog2(NREGS)-1:0] rfRs2Addr,
   input  logic [XLEN-1:0]          rfRs1Data,
   input  logic [XLEN-1:0]          rfRs2Data,
   output decode_t                  uopOut
);

   logic            bufVld;
   logic [31:0]     bufInstr;
   logic [XLEN-1:0] bufPc;
   logic            dValidQ;

   logic            curVld;
   logic [31:0]     curInstr;
   logic [XLEN-1:0] curPc;

   decode_t         dec;
   logic            legal;
   decode_t         curUop;
   logic            emitOk;

   assign curVld   = bufVld ? bufVld   : u.valid;
   assign curInstr = bufVld ? bufInstr : instrIn;
   assign curPc    = bufVld ? bufPc    : pcIn;

   assign u.stall = bufVld;
   assign d.valid = dValidQ;

   instr_decoder decoder (
      .instr (curInstr),
      .dec   (dec),
      .legal (legal)
   );

   assign rfRs1Addr = dec.rs1;
   assign rfRs2Addr = dec.rs2;

   // Operands are read every cycle, so a replayed buffered instruction sees fresh values.
   always_comb begin
      curUop        = dec;
      curUop.rs1val = (dec.rs1 == '0) ? '0 : rfRs1Data;
      curUop.rs2val = (dec.rs2 == '0) ? '0 : rfRs2Data;
      curUop.ex.pc  = curPc;
`ifdef DECODE_ILLEGAL_TRAP_EN
      curUop.ex.cause = legal ? EXC_NONE : EXC_ILLEGAL_INSTR;
      curUop.ex.tval  = legal ? '0 : curInstr;
      emitOk          = curVld;
`else
      curUop.ex.cause = EXC_NONE;
      curUop.ex.tval  = '0;
      emitOk          = curVld & legal;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bufVld   <= 1'b0;
         bufInstr <= '0;
         bufPc    <= '0;
         dValidQ  <= 1'b0;
         uopOut   <= '0;
      end else if (d.stall) begin
         bufVld   <= curVld;
         bufInstr <= curInstr;
         bufPc    <= curPc;
      end else begin
         bufVld   <= 1'b0;
         dValidQ  <= emitOk;
         uopOut   <= curUop;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver queues expected uops on acceptance,
// a monitor compares every uop consumed downstream.
module tb_decode_stage;
   import Uop::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instrIn = '0;
   logic [31:0] pcIn = '0;
   logic [4:0]  rfRs1Addr, rfRs2Addr;
   logic [31:0] rfRs1Data = 32'd7;
   logic [31:0] rfRs2Data = 32'd9;
   decode_t     uopOut;

   pipeline_if uIf ();
   pipeline_if dIf ();

   decode_t sb[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .NREGS(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .u         (uIf),
      .d         (dIf),
      .instrIn   (instrIn),
      .pcIn      (pcIn),
      .rfRs1Addr (rfRs1Addr),
      .rfRs2Addr (rfRs2Addr),
      .rfRs1Data (rfRs1Data),
      .rfRs2Data (rfRs2Data),
      .uopOut    (uopOut)
   );

   function automatic decode_t mk(input fu_e fu, input intaluOp_e op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [31:0] v1, input logic [31:0] v2,
                                  input logic [31:0] imm, input logic immV, input logic [31:0] pc);
      decode_t m;
      m          = '0;
      m.fu       = fu;
      m.op       = op;
      m.rd       = rd;
      m.rs1      = rs1;
      m.rs2      = rs2;
      m.rs1val   = v1;
      m.rs2val   = v2;
      m.imm      = imm;
      m.immValid = immV;
      m.ex.pc    = pc;
      m.ex.cause = EXC_NONE;
      m.ex.tval  = '0;
      return m;
   endfunction

`ifdef DECODE_ILLEGAL_TRAP_EN
   function automatic decode_t mkIll(input logic [31:0] pc, input logic [31:0] ins);
      decode_t m;
      m          = '0;
      m.fu       = FU_NONE;
      m.ex.pc    = pc;
      m.ex.cause = EXC_ILLEGAL_INSTR;
      m.ex.tval  = ins;
      return m;
   endfunction
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // Present one instruction and hold it until accepted; returns #1 after the accepting edge.
   task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                        input decode_t exp, input bit expectOut);
      bit accepted;
      accepted  = 1'b0;
      uIf.valid = 1'b1;
      instrIn   = ins;
      pcIn      = pc;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!uIf.stall) begin
            accepted = 1'b1;
            if (expectOut) sb.push_back(exp);
         end
         @(posedge clk);
         #1;
         if (accepted) break;
      end
      if (!accepted) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout instr=%h got=stalled want=accepted", ins);
      end
   endtask

   task automatic idle(input int n);
      uIf.valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      decode_t e;
      uIf.valid = 1'b0;
      dIf.stall = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (rst && dIf.valid && !dIf.stall) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_uop got=%h want=none", uopOut);
               end else begin
                  e = sb.pop_front();
                  if (uopOut !== e) begin
                     errors++;
                     $display("FAIL uop_rd%0d got=%h want=%h", e.rd, uopOut, e);
                  end
               end
            end
         end
      join_none

      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_dvalid", 32'(dIf.valid), 32'd0);
      chk("reset_ustall", 32'(uIf.stall), 32'd0);
      chk("reset_uop_lo", uopOut[31:0], 32'd0);
      rst = 1'b1;
      idle(1);

      issue(32'h00500093, 32'h100, mk(FU_INTALU, ALU_ADD, 5'd1, 5'd0, 5'd0, 0, 0, 32'd5, 1'b1, 32'h100), 1'b1);
      issue(32'h002081B3, 32'h104, mk(FU_INTALU, ALU_ADD, 5'd3, 5'd1, 5'd2, 7, 9, 32'd0, 1'b0, 32'h104), 1'b1);
      issue(32'h123452B7, 32'h108, mk(FU_INTALU, ALU_ADD, 5'd5, 5'd0, 5'd0, 0, 0, 32'h12345000, 1'b1, 32'h108), 1'b1);
      issue(32'h4030D313, 32'h10C, mk(FU_INTALU, ALU_SRA, 5'd6, 5'd1, 5'd0, 7, 0, 32'h00000403, 1'b1, 32'h10C), 1'b1);
      issue(32'h402083B3, 32'h110, mk(FU_INTALU, ALU_SUB, 5'd7, 5'd1, 5'd2, 7, 9, 32'd0, 1'b0, 32'h110), 1'b1);
      idle(3);
      chk("bubble_dvalid", 32'(dIf.valid), 32'd0);

      // back-to-back with a two-cycle downstream stall after the second
      issue(32'h00100093, 32'h200, mk(FU_INTALU, ALU_ADD, 5'd1, 5'd0, 5'd0, 0, 0, 32'd1, 1'b1, 32'h200), 1'b1);
      issue(32'h00200113, 32'h204, mk(FU_INTALU, ALU_ADD, 5'd2, 5'd0, 5'd0, 0, 0, 32'd2, 1'b1, 32'h204), 1'b1);
      fork
         begin
            issue(32'h00300193, 32'h208, mk(FU_INTALU, ALU_ADD, 5'd3, 5'd0, 5'd0, 0, 0, 32'd3, 1'b1, 32'h208), 1'b1);
            issue(32'h00400213, 32'h20C, mk(FU_INTALU, ALU_ADD, 5'd4, 5'd0, 5'd0, 0, 0, 32'd4, 1'b1, 32'h20C), 1'b1);
         end
         begin
            dIf.stall = 1'b1;
            chk("ustall_before", 32'(uIf.stall), 32'd0);
            @(posedge clk);
            #1;
            chk("ustall_rise", 32'(uIf.stall), 32'd1);
            chk("hold_rd_1", 32'(uopOut.rd), 32'd2);
            chk("hold_valid_1", 32'(dIf.valid), 32'd1);
            @(posedge clk);
            #1;
            chk("hold_rd_2", 32'(uopOut.rd), 32'd2);
            chk("hold_imm_2", uopOut.imm, 32'd2);
            dIf.stall = 1'b0;
         end
      join
      idle(3);

      // illegal encodings: all-zero word, SLLI with nonzero funct7, SUB form on funct3=001
`ifdef DECODE_ILLEGAL_TRAP_EN
      issue(32'h00000000, 32'h300, mkIll(32'h300, 32'h00000000), 1'b1);
      chk("illegal0_dvalid", 32'(dIf.valid), 32'd1);
      issue(32'h02009093, 32'h304, mkIll(32'h304, 32'h02009093), 1'b1);
      chk("illegal_slli_dvalid", 32'(dIf.valid), 32'd1);
      issue(32'h402093B3, 32'h308, mkIll(32'h308, 32'h402093B3), 1'b1);
      chk("illegal_op_dvalid", 32'(dIf.valid), 32'd1);
`else
      issue(32'h00000000, 32'h300, '0, 1'b0);
      chk("illegal0_dvalid", 32'(dIf.valid), 32'd0);
      issue(32'h02009093, 32'h304, '0, 1'b0);
      chk("illegal_slli_dvalid", 32'(dIf.valid), 32'd0);
      issue(32'h402093B3, 32'h308, '0, 1'b0);
      chk("illegal_op_dvalid", 32'(dIf.valid), 32'd0);
`endif
      idle(3);

      // reset while the buffer holds an instruction
      dIf.stall = 1'b1;
      issue(32'h00100093, 32'h400, mk(FU_INTALU, ALU_ADD, 5'd1, 5'd0, 5'd0, 0, 0, 32'd1, 1'b1, 32'h400), 1'b1);
      chk("midstall_ustall", 32'(uIf.stall), 32'd1);
      uIf.valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("midreset_dvalid", 32'(dIf.valid), 32'd0);
      chk("midreset_ustall", 32'(uIf.stall), 32'd0);
      sb.delete();
      dIf.stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      idle(1);
      issue(32'h00900493, 32'h500, mk(FU_INTALU, ALU_ADD, 5'd9, 5'd0, 5'd0, 0, 0, 32'd9, 1'b1, 32'h500), 1'b1);
      idle(4);

      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain got=%0d pending want=0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage ahead of the execute stage; it is the producer on the pipeline_if link that execute consumes.
- Takes a fetched RV32I instruction word plus PC from the fetch stage and decodes it into a Uop::decode_t.
- Reads source operands from the external register file and presents a registered decode_t with valid/stall handshake downstream.
- Holds one instruction in an internal stall buffer, so downstream stall is absorbed without dropping data.

Parameters:
- XLEN, 32, datapath width; must match Uop::val_t.
- NREGS, 32, architectural register count; register index width is log2(NREGS).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- u  pipeline_if.Upstream  -  u.valid (in) = instr/pc valid; u.stall (out) = stage not accepting.
- d  pipeline_if.Downstream  -  d.valid (out) = uopOut valid; d.stall (in) = execute not accepting.
- instrIn  input  32  instruction word, qualified by u.valid.
- pcIn  input  XLEN  instruction address, qualified by u.valid.
- rfRs1Addr  output  5  register file read address 1, combinational from current instruction.
- rfRs2Addr  output  5  register file read address 2.
- rfRs1Data  input  XLEN  combinational read data 1.
- rfRs2Data  input  XLEN  combinational read data 2.
- uopOut  output  decode_t  decoded micro-op, registered.

Behaviour:
- Reset (rst low, async): d.valid=0, uopOut=0, stall buffer empty (u.stall=0), buffered instr/pc/valid cleared. Release is synchronous to clk.
- Current instruction: stall buffer valid ? buffered {instr,pc,valid} : {instrIn,pcIn,u.valid}.
- u.stall = stall buffer valid. It is a registered signal, so upstream sees it one cycle after d.stall.
- Latency: 1 cycle from acceptance to d.valid/uopOut.
- Edge with d.stall=1:
  - buffer captures the current {instr,pc,valid};
  - uopOut and d.valid hold their values.
- Edge with d.stall=0:
  - buffer clears;
  - uopOut is loaded from the current decode;
  - d.valid = current valid AND decode legal.
- Register read is combinational from the current instruction on every cycle. A replayed buffered instruction therefore always re-reads fresh operand values.
- Register x0: rs1val/rs2val are forced to 0 when the index is 0, regardless of rfRsXData.
- Decode rules:
  - OP (0110011): fu=FU_INTALU, immValid=0, op from funct3/funct7[5].
  - OP-IMM (0010011): immValid=1, imm = sign-extended I-imm.
    - SLLI/SRLI/SRAI: shamt = imm[4:0]; funct7[5] selects SRA.
    - SLLI/SRLI with funct7 != 0, and SRAI with funct7 != 0100000, are illegal.
  - LUI (0110111): rs1 forced to 0, immValid=1, imm = {instr[31:12],12'b0}, op=ADD.
  - OP with funct7 not in {0000000,0100000}, or SUB/SRA encodings on the wrong funct3: illegal.
  - Any other opcode: illegal.
- Unused rs2 (immediate forms): rs2=0, rs2val=0.
- uopOut.ex carries pc and exception cause (none when legal).
- u.valid=0 while the buffer is empty: a bubble propagates (d.valid=0 after the next non-stalled edge).
- Simultaneous d.stall=1 and u.valid=1 with the buffer empty: the input is captured into the buffer, nothing is lost, and upstream must hold from the next cycle.
- Reset asserted mid-stall: buffer and output are discarded immediately (async).

Optional Feature:
- DECODE_ILLEGAL_TRAP_EN defined:
  - illegal instructions are not dropped; d.valid follows the current valid;
  - fu=FU_NONE, ex.cause=EXC_ILLEGAL_INSTR, ex.tval=instr.
- Not defined: illegal instructions are silently dropped (d.valid=0), and ex.cause is always none.

Decomposition:
- Uop package gains:
  - opcode constants OPC_OP, OPC_OPIMM, OPC_LUI;
  - funct3/funct7 constants;
  - EXC_ILLEGAL_INSTR and the exception-cause enum;
  - FU_NONE, if not already present.
- decode_t and intalu op enum stay in Uop.
- Sub-module instr_decoder: purely combinational, instr -> {decode_t fields without register values, legal}. decode_stage owns buffering, register read and handshake.

Test Plan:
- Reset, then u.valid=1 with instr=0x00500093 (addi x1,x0,5) -> next cycle d.valid=1, rd=1, rs1=0, imm=5, immValid=1, fu=FU_INTALU, op=ADD, rs1val=0.
- rfRs1Data=7, rfRs2Data=9, instr=0x002081B3 (add x3,x1,x2) -> rd=3, rs1=1, rs2=2, rs1val=7, rs2val=9, immValid=0.
- instr=0x123452B7 (lui x5,0x12345) -> imm=0x12345000, rd=5, rs1val=0.
- Back-to-back addi x1..x4, d.stall high for 2 cycles after the 2nd is issued:
  - u.stall rises one cycle later;
  - uopOut holds;
  - all 4 uops emerge in order, none duplicated or lost.
- instr=0x00000000:
  - without DECODE_ILLEGAL_TRAP_EN, d.valid=0;
  - with it, d.valid=1, ex.cause=EXC_ILLEGAL_INSTR, ex.tval=0.
- Assert rst low mid-stall with the buffer full -> d.valid=0 and u.stall=0 immediately; first uop after release is the new input only.
